// File: rtl/ldtu_bsl_pkg.sv
// Shared types and width constants for the baseline calibration block.
package ldtu_bsl_pkg;

  localparam int Nbits_12 = 12;  // ADC sample width
  localparam int Nbits_8  = 8;   // baseline value width
  localparam int CNT_W    = 8;   // covers SETTLE_CYC up to 255 and 2^8 samples

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    LOAD   = 2'd3
  } bsl_state_t;

endpackage

// File: rtl/ldtu_bsl_accum.sv
// Sample accumulator plus shared cycle counter for the baseline calibration.
// The counter times both the settle window and the accumulation window.
module ldtu_bsl_accum #(
  parameter int DATA_W     = 12,
  parameter int LOG2_NSAMP = 6,
  parameter int CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         cnt_en,
  input  logic                         acc_en,
  input  logic [DATA_W-1:0]            sample,
  output logic [DATA_W+LOG2_NSAMP-1:0] sum,
  output logic [CNT_W-1:0]             cnt,
  output logic                         acc_tc
);

  localparam int ACC_W = DATA_W + LOG2_NSAMP;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'((1 << LOG2_NSAMP) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority; otherwise count and/or accumulate as enabled.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      if (cnt_en) cnt_d = cnt_q + CNT_W'(1);
      if (acc_en) acc_d = acc_q + ACC_W'(sample);
    end
  end

  // Accumulator and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum    = acc_q;
  assign cnt    = cnt_q;
  assign acc_tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/ldtu_bsl_cal.sv
// Baseline calibration: discard SETTLE_CYC samples, average 2^LOG2_NSAMP
// registered samples with round-half-up, saturate to Nbits_8 and publish.
module ldtu_bsl_cal #(
  parameter int Nbits_12   = ldtu_bsl_pkg::Nbits_12,
  parameter int Nbits_8    = ldtu_bsl_pkg::Nbits_8,
  parameter int LOG2_NSAMP = 6,
  parameter int SETTLE_CYC = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [Nbits_12-1:0] DATA12,
  input  logic                cal_start,
  input  logic                cal_abort,
  output logic [Nbits_8-1:0]  BSL_VAL,
  output logic                bsl_valid,
  output logic                cal_busy,
  output logic                cal_done,
  output logic                cal_ovf
);

  import ldtu_bsl_pkg::*;

  localparam int ACC_W = Nbits_12 + LOG2_NSAMP;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [ACC_W:0]   HALF        = (ACC_W+1)'(1) << (LOG2_NSAMP - 1);
  localparam logic [ACC_W:0]   MEAN_MAX    = (ACC_W+1)'((1 << Nbits_8) - 1);

  // Round-half-up mean with saturation; MSB of the result is the clamp flag.
  function automatic logic [Nbits_8:0] sat_mean(input logic [ACC_W-1:0] acc);
    logic [ACC_W:0] rnd;
    logic [ACC_W:0] mean;
    rnd  = {1'b0, acc} + HALF;
    mean = rnd >> LOG2_NSAMP;
    if (mean > MEAN_MAX) sat_mean = {1'b1, {Nbits_8{1'b1}}};
    else                 sat_mean = {1'b0, mean[Nbits_8-1:0]};
  endfunction

  bsl_state_t          state_q, state_d;
  logic [Nbits_12-1:0] sample_q;
  logic [Nbits_8-1:0]  bsl_val_q, bsl_val_d;
  logic                bsl_valid_q, bsl_valid_d;
  logic                cal_done_q, cal_done_d;
  logic                cal_ovf_q, cal_ovf_d;

  logic                clr, cnt_en, acc_en, acc_tc;
  logic [ACC_W-1:0]    acc_sum;
  logic [CNT_W-1:0]    cnt;

  ldtu_bsl_accum #(
    .DATA_W    (Nbits_12),
    .LOG2_NSAMP(LOG2_NSAMP),
    .CNT_W     (CNT_W)
  ) u_accum (
    .clk   (CLK),
    .rst   (reset),
    .clr   (clr),
    .cnt_en(cnt_en),
    .acc_en(acc_en),
    .sample(sample_q),
    .sum   (acc_sum),
    .cnt   (cnt),
    .acc_tc(acc_tc)
  );

  // Next-state and result computation; published outputs change only in LOAD.
  always_comb begin
    state_d     = state_q;
    clr         = 1'b0;
    cnt_en      = 1'b0;
    acc_en      = 1'b0;
    bsl_val_d   = bsl_val_q;
    bsl_valid_d = bsl_valid_q;
    cal_ovf_d   = cal_ovf_q;
    cal_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cal_start && !cal_abort) begin
          state_d = SETTLE;
          clr     = 1'b1;
        end
      end
      SETTLE: begin
        if (cal_abort) begin
          state_d = IDLE;
        end else if (cnt == SETTLE_LAST) begin
          state_d = ACCUM;
          clr     = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ACCUM: begin
        if (cal_abort) begin
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
          acc_en = 1'b1;
          if (acc_tc) state_d = LOAD;
        end
      end
      LOAD: begin
        {cal_ovf_d, bsl_val_d} = sat_mean(acc_sum);
        bsl_valid_d            = 1'b1;
        cal_done_d             = 1'b1;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Input sample register, FSM state and published result registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      bsl_val_q   <= '0;
      bsl_valid_q <= 1'b0;
      cal_done_q  <= 1'b0;
      cal_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= DATA12;
      bsl_val_q   <= bsl_val_d;
      bsl_valid_q <= bsl_valid_d;
      cal_done_q  <= cal_done_d;
      cal_ovf_q   <= cal_ovf_d;
    end
  end

  assign BSL_VAL   = bsl_val_q;
  assign bsl_valid = bsl_valid_q;
  assign cal_busy  = (state_q != IDLE);
  assign cal_done  = cal_done_q;
  assign cal_ovf   = cal_ovf_q;

endmodule

// File: doc/ldtu_bsl_cal.md
LDTU_BSL_CAL -- requirements
Module: ldtu_bsl_cal

Interface
REQ-001 Parameter Nbits_12, default 12, ADC sample width.
REQ-002 Parameter Nbits_8, default 8, baseline value width.
REQ-003 Parameter LOG2_NSAMP, default 6, log2 of averaged sample count; legal range 2..8.
REQ-004 Parameter SETTLE_CYC, default 16, discarded samples before accumulation; legal range 1..255.
REQ-005 CLK  in  1  single block clock, the ADC sample clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 DATA12  in  Nbits_12  raw ADC sample, one per CLK.
REQ-008 cal_start  in  1  one-cycle calibration request.
REQ-009 cal_abort  in  1  one-cycle abort request.
REQ-010 BSL_VAL  out  Nbits_8  calibrated baseline for the subtraction datapath.
REQ-011 bsl_valid  out  1  level; high once any calibration has completed.
REQ-012 cal_busy  out  1  high in every state except IDLE.
REQ-013 cal_done  out  1  one-cycle pulse on calibration completion.
REQ-014 cal_ovf  out  1  set when the last completed mean was clamped.

Function
REQ-015 DATA12 SHALL be registered once before use; only the registered sample feeds the accumulator.
REQ-016 FSM SHALL have states IDLE, SETTLE, ACCUM, LOAD.
REQ-017 IDLE -> SETTLE on cal_start=1 and cal_abort=0; the cycle counter and accumulator clear on this edge.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to ACCUM.
REQ-019 ACCUM SHALL add exactly 2^LOG2_NSAMP consecutive registered samples, one per cycle, then go to LOAD.
REQ-020 Accumulator width SHALL be Nbits_12+LOG2_NSAMP bits; overflow is impossible by construction.
REQ-021 LOAD SHALL compute mean = (acc + 2^(LOG2_NSAMP-1)) >> LOG2_NSAMP, i.e. round half up.
REQ-022 If mean > 255, BSL_VAL SHALL load 255 and cal_ovf SHALL be 1; otherwise BSL_VAL loads mean and cal_ovf is 0.
REQ-023 In LOAD the block SHALL assert cal_done for one cycle, set bsl_valid, and return to IDLE on the next edge.
REQ-024 Latency: with cal_start sampled at edge 0, cal_done SHALL be high in cycle SETTLE_CYC+2^LOG2_NSAMP+1 (default 81).
REQ-025 BSL_VAL, bsl_valid and cal_ovf SHALL hold their previous values throughout SETTLE and ACCUM.
REQ-026 cal_start while cal_busy=1 SHALL be ignored.
REQ-027 cal_abort in SETTLE or ACCUM SHALL return to IDLE next edge, with no cal_done and no output update.
REQ-028 cal_abort in LOAD SHALL be ignored; the result commits.
REQ-029 If cal_start and cal_abort are both high in IDLE, abort wins and the block stays in IDLE.

Reset
REQ-030 On reset all registers SHALL clear asynchronously: state=IDLE, BSL_VAL=0, bsl_valid=0, cal_busy=0, cal_done=0, cal_ovf=0, accumulator=0, counter=0.
REQ-031 Reset mid-calibration SHALL discard the partial accumulation; the first edge after reset release leaves the FSM in IDLE.

Structure
REQ-032 Package ldtu_bsl_pkg SHALL hold the state enum and the width constants Nbits_12 and Nbits_8.
REQ-033 Accumulator and sample counter SHALL be a sub-module ldtu_bsl_accum (clear, enable, sum, terminal-count outputs).

Verification (default parameters)
REQ-034 DATA12 constant 100; pulse cal_start -> cal_done in cycle 81, BSL_VAL=100, bsl_valid=1, cal_ovf=0.
REQ-035 DATA12 constant 4095 -> BSL_VAL=255, cal_ovf=1; a second run with 50 -> BSL_VAL=50, cal_ovf=0.
REQ-036 DATA12 alternating 10/11 over ACCUM -> mean 10.5 rounds to BSL_VAL=11.
REQ-037 After a completed run giving 100, run with 200 and pulse cal_abort in ACCUM cycle 20 -> no cal_done, BSL_VAL stays 100, cal_busy=0 next cycle.
REQ-038 cal_start repeated in SETTLE is ignored, so done timing is unchanged; cal_start+cal_abort together in IDLE -> cal_busy stays 0.
REQ-039 Assert reset in ACCUM -> all outputs 0 immediately; a new run after release gives the correct mean.
